// File: rtl/ioctl_sdram_loader_pkg.sv
// loader_pkg: shared definitions for the ioctl -> SDRAM download loader.
//   state_e            FSM states; the encoding is what state_dbg shows
//   DATA_W_* / FIFO_*  legal configuration ranges
//   legal_data_w()     true for the supported memory word widths
//   legal_fifo_depth() true for a power-of-two depth inside the legal range
package loader_pkg;

    localparam int STATE_W        = 3;
    localparam int DATA_W_MIN     = 8;
    localparam int DATA_W_MAX     = 32;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic bit legal_data_w(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    function automatic bit legal_fifo_depth(input int d);
        return (d >= FIFO_DEPTH_MIN) && (d <= FIFO_DEPTH_MAX) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/ioctl_sdram_loader_if.sv
// ioctl_sdram_loader_if: byte download bus from the HPS plus the SDRAM write port.
//   master : HPS / memory environment (drives ioctl_*, mem_ack)
//   slave  : the loader (drives ioctl_wait and the mem_* request)
interface ioctl_sdram_loader_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic                  ioctl_download;
    logic                  ioctl_wr;
    logic [ADDR_W-1:0]     ioctl_addr;
    logic [7:0]            ioctl_dout;
    logic [7:0]            ioctl_index;
    logic                  ioctl_wait;

    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_din;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, mem_ack,
        input  ioctl_wait, mem_req, mem_addr, mem_din, mem_be
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, mem_ack,
        output ioctl_wait, mem_req, mem_addr, mem_din, mem_be
    );
endinterface

// File: rtl/ioctl_sdram_loader_fifo.sv
// loader_fifo: synchronous write buffer for assembled memory words.
//   push/push_data  write side; a push while full is discarded
//   pop/pop_data    read side; pop_data shows the head word (first-word fall-through)
//   empty/full      status; count = current occupancy (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap on their own.
module loader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // simultaneous push and pop cancel out
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: packs HPS download bytes into DATA_W words and writes them
// to SDRAM at REGION_BASE[ioctl_index] + offset through a small write buffer.
//   clk_sys, reset_n  clock, async active-low reset
//   bus (slave)       ioctl byte stream in, ioctl_wait out, mem_req/addr/din/be out, mem_ack in
//   busy              high outside IDLE
//   done              one-cycle pulse in DONE
//   err_index         sticky: a download used an unmapped ioctl_index
//   state_dbg         current FSM encoding
//   checksum          (IOCTL_SDRAM_LOADER_CHECKSUM_EN only) 16-bit sum of accepted bytes
module ioctl_sdram_loader
    import loader_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 25,
    parameter int FIFO_DEPTH  = 8,
    parameter int NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    ioctl_sdram_loader_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_index,
    output logic [STATE_W-1:0]   state_dbg
`ifdef IOCTL_SDRAM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);
    localparam int NB = DATA_W / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W + NB;

    if (!legal_data_w(DATA_W) || !legal_fifo_depth(FIFO_DEPTH)) begin : g_bad_cfg
        $error("ioctl_sdram_loader: illegal DATA_W or FIFO_DEPTH");
    end

    state_e            state_q, state_nx;
    logic              drop_q, err_q, wait_q;
    logic [ADDR_W-1:0] base_q, base_sel;
    logic [DATA_W-1:0] asm_data, merge_data;
    logic [NB-1:0]     asm_be, merge_be;
    logic [ADDR_W-1:0] asm_addr, byte_waddr;
    logic [LW-1:0]     lane;
    logic              idx_bad, byte_ok, pending, stale, top_lane;
    logic              push, push_ok, pop;
    logic [EW-1:0]     push_word, fifo_q;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_cnt;
    int                cnt_nx;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic [NB-1:0]     mem_be_q;

    always_comb begin
        base_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (bus.ioctl_index == 8'(i)) base_sel = REGION_BASE[i*ADDR_W +: ADDR_W];
    end
    assign idx_bad = int'(bus.ioctl_index) >= NUM_REGIONS;

    assign byte_waddr = bus.ioctl_addr & ~ADDR_W'(NB - 1);
    assign lane       = LW'(bus.ioctl_addr - byte_waddr);
    assign top_lane   = (lane == LW'(NB - 1));
    assign byte_ok    = (state_q == ST_LOAD) && bus.ioctl_download && bus.ioctl_wr && !drop_q;
    assign pending    = |asm_be;
    assign stale      = byte_ok && pending && (byte_waddr != asm_addr);

    // A byte for a new word address starts from a clean word; otherwise it merges.
    always_comb begin
        merge_data = stale ? '0 : asm_data;
        merge_be   = stale ? '0 : asm_be;
        for (int b = 0; b < NB; b++)
            if (lane == LW'(b)) begin
                merge_data[b*8 +: 8] = bus.ioctl_dout;
                merge_be[b]          = 1'b1;
            end
    end

    always_comb begin
        state_nx  = state_q;
        push      = 1'b0;
        push_word = {ADDR_W'(base_q + asm_addr), asm_data, asm_be};
        case (state_q)
            ST_IDLE:  if (bus.ioctl_download) state_nx = ST_LOAD;
            ST_LOAD: begin
                if (!bus.ioctl_download) state_nx = ST_FLUSH;
                else if (byte_ok) begin
                    // Stale partial word goes out now. If the new byte is also a
                    // top lane it stays pending and leaves with the next push.
                    if (stale) push = 1'b1;
                    else if (top_lane) begin
                        push      = 1'b1;
                        push_word = {ADDR_W'(base_q + byte_waddr), merge_data, merge_be};
                    end
                end
            end
            ST_FLUSH: begin
                push = pending && !fifo_full;
                if (!pending || !fifo_full) state_nx = ST_DRAIN;
            end
            ST_DRAIN: if (fifo_empty && !mem_req_q) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign push_ok = push && !fifo_full;
    assign pop     = !fifo_empty && !mem_req_q;
    assign cnt_nx  = int'(fifo_cnt) + int'(push_ok) - int'(pop);

    loader_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (fifo_q),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            wait_q   <= 1'b0;
            asm_data <= '0;
            asm_be   <= '0;
            asm_addr <= '0;
        end else begin
            state_q <= state_nx;
            // wait tracks the occupancy the FIFO will hold after this edge,
            // and stays up from end-of-download until IDLE
            wait_q  <= (cnt_nx >= FIFO_DEPTH - 1) ||
                       (state_nx inside {ST_FLUSH, ST_DRAIN, ST_DONE});
            if (state_q == ST_IDLE && state_nx == ST_LOAD) begin
                base_q <= base_sel;
                drop_q <= idx_bad;
                if (idx_bad) err_q <= 1'b1;
            end
            if (state_q == ST_IDLE || (state_q == ST_FLUSH && push)) begin
                asm_data <= '0;
                asm_be   <= '0;
                asm_addr <= '0;
            end else if (byte_ok) begin
                if (!stale && top_lane) begin
                    asm_data <= '0;
                    asm_be   <= '0;
                    asm_addr <= '0;
                end else begin
                    asm_data <= merge_data;
                    asm_be   <= merge_be;
                    asm_addr <= byte_waddr;
                end
            end
        end
    end

    // Output stage: a word is fetched only while no request is outstanding, so
    // the bus stays stable under mem_req and the next word follows a cycle later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
        end else if (mem_req_q) begin
            if (bus.mem_ack) mem_req_q <= 1'b0;
        end else if (pop) begin
            mem_req_q <= 1'b1;
            {mem_addr_q, mem_din_q, mem_be_q} <= fifo_q;
        end
    end

`ifdef IOCTL_SDRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                                     checksum <= '0;
        else if (state_q == ST_IDLE && state_nx == ST_LOAD) checksum <= '0;
        else if (byte_ok)                                 checksum <= checksum + 16'(bus.ioctl_dout);
    end
`endif

    assign bus.ioctl_wait = wait_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_be     = mem_be_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign err_index      = err_q;
    assign state_dbg      = state_q;
endmodule
